// File: rtl/fsk_tone_sequencer.sv
// rtl/fsk_tone_sequencer.sv - mark/space Goertzel window sequencer with squelched bit decision
// Drives both filters' start strobe, collects the two window powers and hands one bit per symbol downstream.
module fsk_tone_sequencer #(
  parameter int POWER_WIDTH   = 56,
  parameter int WINDOW_SIZE   = 1067,
  parameter int TIMEOUT_SLACK = 8,
  parameter int SYM_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     filt_start,
  input  logic                     mark_valid,
  input  logic [POWER_WIDTH-1:0]   mark_power,
  input  logic                     space_valid,
  input  logic [POWER_WIDTH-1:0]   space_power,
  input  logic [POWER_WIDTH-1:0]   squelch_thr,
  output logic                     bit_valid,
  input  logic                     bit_ready,
  output logic                     bit_value,
  output logic                     bit_squelch,
  output logic                     overrun,
  output logic                     timeout_err,
  output logic [SYM_CNT_WIDTH-1:0] sym_count
);

  localparam int LIMIT = WINDOW_SIZE + TIMEOUT_SLACK;
  localparam int CNT_W = $clog2(LIMIT + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_ACCUM  = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic                   mark_have, space_have;
  logic [POWER_WIDTH-1:0] mark_lat, space_lat;
  logic                   last_bit;

  logic mark_take, space_take, both_now, at_limit, clear_lat;
  logic load, handshake;

  logic [POWER_WIDTH-1:0] mark_c, space_c, win_pow;
  logic                   dec_bit, dec_sq;

  // Filter strobes only count while a window is accumulating.
  assign mark_take  = (state == S_ACCUM) && enable && mark_valid;
  assign space_take = (state == S_ACCUM) && enable && space_valid;
  assign both_now   = (mark_have || mark_take) && (space_have || space_take);
  assign at_limit   = (cnt >= CNT_W'(LIMIT));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    clear_lat   = 1'b0;
    filt_start  = 1'b0;
    timeout_err = 1'b0;
    if (!enable) begin
      state_nx  = S_IDLE;
      cnt_nx    = '0;
      clear_lat = 1'b1;
    end else begin
      case (state)
        S_IDLE: state_nx = S_ARM;
        S_ARM: begin
          filt_start = 1'b1;
          clear_lat  = 1'b1;
          cnt_nx     = in_valid ? CNT_W'(1) : '0;
          state_nx   = S_ACCUM;
        end
        S_ACCUM: begin
          if (in_valid && !at_limit) cnt_nx = cnt + CNT_W'(1);
          // A result landing on the limit cycle still completes the window.
          if (both_now) begin
            state_nx = S_DECIDE;
          end else if (at_limit) begin
            timeout_err = 1'b1;
            state_nx    = S_ARM;
          end
        end
        S_DECIDE: state_nx = S_ARM;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Negative powers are filter noise; treat them as zero energy.
  always_comb begin
    mark_c  = mark_lat[POWER_WIDTH-1]  ? '0 : mark_lat;
    space_c = space_lat[POWER_WIDTH-1] ? '0 : space_lat;
    if (mark_c > space_c) begin
      dec_bit = 1'b1;
      win_pow = mark_c;
    end else if (space_c > mark_c) begin
      dec_bit = 1'b0;
      win_pow = space_c;
    end else begin
      dec_bit = last_bit;
      win_pow = mark_c;
    end
    dec_sq = (win_pow < squelch_thr);
  end

  assign load      = (state == S_DECIDE) && enable;
  assign handshake = bit_valid && bit_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mark_have  <= 1'b0;
      space_have <= 1'b0;
      mark_lat   <= '0;
      space_lat  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (clear_lat) begin
        mark_have  <= 1'b0;
        space_have <= 1'b0;
      end else begin
        if (mark_take) begin
          mark_have <= 1'b1;
          mark_lat  <= mark_power;
        end
        if (space_take) begin
          space_have <= 1'b1;
          space_lat  <= space_power;
        end
      end
    end
  end

  // Single-entry output register; a new decision always wins over an unread one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_valid   <= 1'b0;
      bit_value   <= 1'b0;
      bit_squelch <= 1'b0;
      overrun     <= 1'b0;
      sym_count   <= '0;
      last_bit    <= 1'b1;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        bit_valid   <= 1'b1;
        bit_value   <= dec_bit;
        bit_squelch <= dec_sq;
        last_bit    <= dec_bit;
        sym_count   <= sym_count + SYM_CNT_WIDTH'(1);
        overrun     <= bit_valid && !bit_ready;
      end else if (handshake) begin
        bit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_tone_sequencer.sv
// tb/tb_fsk_tone_sequencer.sv - randomized window-level bench for fsk_tone_sequencer
// Inputs change 1ns after posedge; outputs are checked on negedge against a symbol-level model.
module tb_fsk_tone_sequencer;

  localparam int PW    = 56;
  localparam int WS    = 1067;
  localparam int SLACK = 8;
  localparam int SCW   = 16;
  localparam int LIMIT = WS + SLACK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          mark_valid = 1'b0;
  logic          space_valid = 1'b0;
  logic          bit_ready = 1'b0;
  logic [PW-1:0] mark_power = '0;
  logic [PW-1:0] space_power = '0;
  logic [PW-1:0] squelch_thr = '0;
  logic          filt_start, bit_valid, bit_value, bit_squelch, overrun, timeout_err;
  logic [SCW-1:0] sym_count;

  fsk_tone_sequencer #(
    .POWER_WIDTH(PW), .WINDOW_SIZE(WS), .TIMEOUT_SLACK(SLACK), .SYM_CNT_WIDTH(SCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .filt_start(filt_start),
    .mark_valid(mark_valid), .mark_power(mark_power),
    .space_valid(space_valid), .space_power(space_power),
    .squelch_thr(squelch_thr),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_value(bit_value),
    .bit_squelch(bit_squelch), .overrun(overrun), .timeout_err(timeout_err),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Symbol-level model: pending output bit, expected overrun, decided count, tie memory.
  bit            pend_v = 0, pend_b = 0, pend_s = 0, exp_ovr = 0, last_bit = 1;
  int            exp_sym = 0;
  bit            rdy_en = 0;
  logic [PW-1:0] win_mp, win_sp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [PW-1:0] gen_power();
    logic [PW-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = PW'($urandom_range(0, 5000));
      1:       v = -PW'($urandom_range(1, 5000));
      2:       v = PW'({$urandom(), $urandom()});
      default: v = PW'($urandom_range(0, 1000));
    endcase
    return v;
  endfunction

  // One clock: caller has already driven this cycle's inputs.
  task automatic cycle(input bit exp_fs, input bit exp_to, input bit load, input bit ld_b, input bit ld_s);
    bit hs;
    bit_ready = rdy_en && chance(75);
    @(negedge clk);
    check_eq("filt_start", 64'(filt_start), 64'(exp_fs));
    check_eq("timeout_err", 64'(timeout_err), 64'(exp_to));
    check_eq("bit_valid", 64'(bit_valid), 64'(pend_v));
    if (pend_v) begin
      check_eq("bit_value", 64'(bit_value), 64'(pend_b));
      check_eq("bit_squelch", 64'(bit_squelch), 64'(pend_s));
    end
    check_eq("overrun", 64'(overrun), 64'(exp_ovr));
    check_eq("sym_count", 64'(sym_count), 64'(exp_sym[SCW-1:0]));
    hs = pend_v && bit_ready;
    exp_ovr = load && pend_v && !hs;
    if (load) begin
      pend_v = 1; pend_b = ld_b; pend_s = ld_s;
      exp_sym++;
    end else if (hs) begin
      pend_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one window from its start-strobe cycle. mk/sk: sample-cycle of the result
  // (0 = never, -1 = on the limit cycle). drop_at: cycle at which enable is pulled.
  task automatic run_window(input int mk, input int sk, input int iv_pct, input int drop_at);
    int  s;
    bit  hm, hsp, ms, ss, both, tmo, b, sq;
    longint mv, sv, win, thr;
    hm = 0; hsp = 0;
    in_valid = chance(iv_pct);
    mark_valid = chance(50); space_valid = chance(50);
    mark_power = gen_power(); space_power = gen_power();
    s = int'(in_valid);
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k < 5000; k++) begin
      in_valid = chance(iv_pct);
      if (drop_at == k) begin
        enable = 0; mark_valid = 0; space_valid = 0;
        cycle(0, 0, 0, 0, 0);
        return;
      end
      ms = !hm && ((mk == k) || (mk < 0 && s >= LIMIT));
      ss = !hsp && ((sk == k) || (sk < 0 && s >= LIMIT));
      mark_valid = ms; space_valid = ss;
      mark_power  = ms ? win_mp : gen_power();
      space_power = ss ? win_sp : gen_power();
      hm = hm | ms; hsp = hsp | ss;
      both = hm && hsp;
      tmo  = !both && (s >= LIMIT);
      cycle(0, tmo, 0, 0, 0);
      if (both) begin
        mv = longint'($signed(win_mp)); if (mv < 0) mv = 0;
        sv = longint'($signed(win_sp)); if (sv < 0) sv = 0;
        b = (mv > sv) ? 1'b1 : (sv > mv) ? 1'b0 : last_bit;
        win = (mv > sv) ? mv : sv;
        thr = longint'({8'd0, squelch_thr});
        sq = (win < thr);
        last_bit = b;
        in_valid = chance(iv_pct);
        mark_valid = chance(50); space_valid = chance(50);
        cycle(0, 0, 1, b, sq);
        return;
      end
      if (tmo) return;
      s += int'(in_valid);
    end
    check_eq("window_bound", 64'(1), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mk, sk;
    repeat (2) @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    rst_n = 1;
    cycle(0, 0, 0, 0, 0);
    enable = 1;
    cycle(0, 0, 0, 0, 0);

    squelch_thr = PW'(1000); win_mp = PW'(5000); win_sp = PW'(100); rdy_en = 0;
    run_window(1066, 1066, 100, 0);
    rdy_en = 1; win_mp = PW'(10); win_sp = PW'(900);
    run_window(10, 13, 100, 0);
    run_window(20, 0, 100, 0);
    rdy_en = 0; win_mp = PW'(4000); win_sp = PW'(1);
    run_window(30, 40, 100, 0);
    win_mp = PW'(1); win_sp = PW'(4000);
    run_window(25, 25, 100, 0);
    rdy_en = 1; win_mp = PW'(600); win_sp = PW'(5);
    run_window(12, 15, 100, 0);
    win_mp = PW'(777); win_sp = PW'(777);
    run_window(17, 11, 100, 0);
    rdy_en = 0; win_mp = -PW'(5); win_sp = PW'(3);
    run_window(9, 9, 100, 0);

    run_window(200, 200, 100, 7);
    repeat (4) begin
      in_valid = chance(50);
      cycle(0, 0, 0, 0, 0);
    end
    enable = 1;
    cycle(0, 0, 0, 0, 0);
    win_mp = PW'(3); win_sp = PW'(2);
    run_window(-1, -1, 100, 0);

    for (int w = 0; w < 9; w++) begin
      rdy_en = chance(70);
      squelch_thr = chance(80) ? PW'($urandom_range(0, 6000)) : PW'({$urandom(), $urandom()});
      win_mp = gen_power();
      win_sp = chance(25) ? win_mp : gen_power();
      mk = chance(10) ? 0 : chance(15) ? -1 : $urandom_range(1, 1080);
      sk = chance(10) ? 0 : chance(15) ? -1 : $urandom_range(1, 1080);
      run_window(mk, sk, $urandom_range(60, 100), 0);
    end

    in_valid = 1; mark_valid = 0; space_valid = 0;
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    pend_v = 0; exp_ovr = 0; exp_sym = 0; last_bit = 1;
    check_eq("rst_bit_valid", 64'(bit_valid), 64'(0));
    check_eq("rst_sym_count", 64'(sym_count), 64'(0));
    check_eq("rst_filt_start", 64'(filt_start), 64'(0));
    check_eq("rst_bit_value", 64'(bit_value), 64'(0));
    enable = 0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0);
    rst_n = 1;
    cycle(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
